// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and constants for the three-requester L2 port arbiter.
// Holds the FSM state enum, requester ids and the winner-selection rule.
package l2_port_arbiter_pkg;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_I  = 2'd0,
    REQ_D  = 2'd1,
    REQ_PF = 2'd2
  } req_id_e;

  // Starved icache/pf beat dcache; otherwise dcache > icache > pf.
  function automatic req_id_e pick_winner(input logic i_req, input logic d_req,
                                          input logic pf_req, input logic i_starved,
                                          input logic pf_starved);
    if (i_req && i_starved)   return REQ_I;
    if (pf_req && pf_starved) return REQ_PF;
    if (d_req)                return REQ_D;
    if (i_req)                return REQ_I;
    return REQ_PF;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle of requester-side and L2-side signals of the L2 port arbiter.
// The arb modport is the arbiter's view; tb is the environment's view.
interface l2_port_arbiter_if;
  import l2_port_arbiter_pkg::*;

  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [DATA_W-1:0] dcache_wdata;
  logic              dcache_resp;
  logic              pf_read;
  logic [ADDR_W-1:0] pf_address;
  logic              pf_resp;
  logic [DATA_W-1:0] rdata;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [DATA_W-1:0] l2_wdata;
  logic [DATA_W-1:0] l2_rdata;
  logic              l2_resp;

  modport arb (
    input  icache_read, icache_address, dcache_read, dcache_write,
           dcache_address, dcache_wdata, pf_read, pf_address, l2_rdata, l2_resp,
    output icache_resp, dcache_resp, pf_resp, rdata, l2_read, l2_write,
           l2_address, l2_wdata
  );

  modport tb (
    output icache_read, icache_address, dcache_read, dcache_write,
           dcache_address, dcache_wdata, pf_read, pf_address, l2_rdata, l2_resp,
    input  icache_resp, dcache_resp, pf_resp, rdata, l2_read, l2_write,
           l2_address, l2_wdata
  );
endinterface

// File: rtl/l2_arb_age_counter.sv
// Saturating count of consecutive lost arbitrations for one requester.
// starved is high while the count sits at LIMIT.
module l2_arb_age_counter #(
  parameter int LIMIT = 8,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign starved = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates icache, dcache and prefetcher line requests onto one L2 port,
// with starvation override for icache/pf against a continuously busy dcache.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic             clk,
  input logic             reset_n,
  l2_port_arbiter_if.arb  bus
);

  arb_state_e        state, state_nxt;
  req_id_e           id;
  req_id_e           winner;
  logic              d_req;
  logic              any_req;
  logic              arb_fire;
  logic              i_starved;
  logic              pf_starved;
  logic              grant_write;
  logic [ADDR_W-1:0] grant_address;

  assign d_req    = bus.dcache_read | bus.dcache_write;
  assign any_req  = bus.icache_read | d_req | bus.pf_read;
  assign arb_fire = (state == IDLE) && any_req;
  assign winner   = pick_winner(bus.icache_read, d_req, bus.pf_read, i_starved, pf_starved);

  // A dcache grant with write asserted is a writeback even if read is also high.
  assign grant_write = (winner == REQ_D) && bus.dcache_write;

  always_comb begin
    grant_address = bus.pf_address;
    case (winner)
      REQ_I:   grant_address = bus.icache_address;
      REQ_D:   grant_address = bus.dcache_address;
      default: grant_address = bus.pf_address;
    endcase
  end

  l2_arb_age_counter #(.LIMIT(STARVE_LIMIT)) u_i_age (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (arb_fire && bus.icache_read && (winner != REQ_I)),
    .clr     (arb_fire && (winner == REQ_I)),
    .starved (i_starved)
  );

  l2_arb_age_counter #(.LIMIT(STARVE_LIMIT)) u_pf_age (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (arb_fire && bus.pf_read && (winner != REQ_PF)),
    .clr     (arb_fire && (winner == REQ_PF)),
    .starved (pf_starved)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (bus.l2_resp) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command/address/data are registered at grant and held until L2 answers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id             <= REQ_I;
      bus.l2_read    <= 1'b0;
      bus.l2_write   <= 1'b0;
      bus.l2_address <= '0;
      bus.l2_wdata   <= '0;
      bus.rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            id             <= winner;
            bus.l2_read    <= !grant_write;
            bus.l2_write   <= grant_write;
            bus.l2_address <= grant_address;
            if (grant_write) bus.l2_wdata <= bus.dcache_wdata;
          end
        end
        ACCESS: begin
          if (bus.l2_resp) begin
            bus.l2_read  <= 1'b0;
            bus.l2_write <= 1'b0;
            if (bus.l2_read) bus.rdata <= bus.l2_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.icache_resp = (state == RESPOND) && (id == REQ_I);
  assign bus.dcache_resp = (state == RESPOND) && (id == REQ_D);
  assign bus.pf_resp     = (state == RESPOND) && (id == REQ_PF);

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive lost arbitrations after which icache or prefetcher is force-granted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port icache_read, input, 1, icache line-read request.
REQ-005 SHALL have port icache_address, input, 32, icache line address.
REQ-006 SHALL have port icache_resp, output, 1, icache completion pulse.
REQ-007 SHALL have port dcache_read, input, 1, dcache line-read request.
REQ-008 SHALL have port dcache_write, input, 1, dcache line-writeback request.
REQ-009 SHALL have port dcache_address, input, 32, dcache line address.
REQ-010 SHALL have port dcache_wdata, input, 256, dcache writeback line.
REQ-011 SHALL have port dcache_resp, output, 1, dcache completion pulse.
REQ-012 SHALL have port pf_read, input, 1, prefetcher line-read request (read-only requester).
REQ-013 SHALL have port pf_address, input, 32, prefetch line address.
REQ-014 SHALL have port pf_resp, output, 1, prefetch completion pulse.
REQ-015 SHALL have port rdata, output, 256, registered read line, shared by all requesters.
REQ-016 SHALL have port l2_read, output, 1, read command to L2.
REQ-017 SHALL have port l2_write, output, 1, write command to L2.
REQ-018 SHALL have port l2_address, output, 32, registered L2 address.
REQ-019 SHALL have port l2_wdata, output, 256, registered L2 write line.
REQ-020 SHALL have port l2_rdata, input, 256, L2 read line, valid when l2_resp is high.
REQ-021 SHALL have port l2_resp, input, 1, L2 completion pulse.

Function
REQ-022 SHALL implement FSM with states IDLE, ACCESS and RESPOND.
REQ-023 In IDLE with any request pending, SHALL select one winner, latch its id, op, address and wdata, and enter ACCESS next cycle; with no request pending, SHALL remain in IDLE.
REQ-024 Default priority SHALL be dcache > icache > pf.
REQ-025 Override: icache or pf whose starvation count equals STARVE_LIMIT SHALL win over dcache; if both are starved, icache wins.
REQ-026 Starvation count SHALL increment when its requester is pending in IDLE and loses, saturate at STARVE_LIMIT, and clear when that requester is granted.
REQ-027 In ACCESS, exactly one of l2_read/l2_write SHALL be high, and l2_address/l2_wdata SHALL be held stable until l2_resp.
REQ-028 On l2_resp in ACCESS: read transactions SHALL load l2_rdata into rdata; l2 commands SHALL drop next cycle; FSM SHALL enter RESPOND.
REQ-029 In RESPOND, SHALL pulse only the winner's resp for exactly one cycle, then return to IDLE.
REQ-030 Zero-wait L2 latency: request seen in IDLE at cycle N, l2_read at N+1, resp at N+2.
REQ-031 rdata SHALL hold its value across write transactions and until the next read completion.
REQ-032 dcache_read and dcache_write both high SHALL be treated as a write.
REQ-033 A requester deasserting mid-transaction SHALL NOT abort it; resp SHALL still be pulsed.
REQ-034 l2_resp outside ACCESS SHALL be ignored.

Reset
REQ-035 reset_n low SHALL asynchronously force IDLE, all outputs to 0, rdata to 0 and starvation counts to 0.
REQ-036 Reset during ACCESS SHALL abandon the transaction with no resp pulse; after release, arbitration restarts from IDLE.

Structure
REQ-037 A shared package SHALL hold the state enum, the requester-id enum (REQ_I, REQ_D, REQ_PF) and the STARVE_LIMIT default.
REQ-038 SHALL instantiate sub-module l2_arb_age_counter (saturating starvation counter) twice, once for icache and once for pf.

Verification
REQ-039 Only icache_read, address 0x0000_1000, L2 responds in the first ACCESS cycle -> l2_read at N+1, icache_resp at N+2, rdata equals l2_rdata.
REQ-040 dcache_write and icache_read together -> dcache granted first with l2_write and l2_wdata matching; icache served next, each with a single resp.
REQ-041 dcache requests continuously while pf_read is held -> pf granted on arbitration 9 (STARVE_LIMIT=8), and its count then clears.
REQ-042 Read completes with 0xAA.. pattern, then dcache write completes -> rdata stays 0xAA.. pattern.
REQ-043 reset_n pulsed low during ACCESS -> outputs 0 immediately, no resp; next request served normally.
